// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and small operand/result helpers.
package muldiv_pkg;

   localparam logic [2:0] MULDIV_OP_MUL    = 3'd0;
   localparam logic [2:0] MULDIV_OP_MULH   = 3'd1;
   localparam logic [2:0] MULDIV_OP_MULHSU = 3'd2;
   localparam logic [2:0] MULDIV_OP_MULHU  = 3'd3;
   localparam logic [2:0] MULDIV_OP_DIV    = 3'd4;
   localparam logic [2:0] MULDIV_OP_DIVU   = 3'd5;
   localparam logic [2:0] MULDIV_OP_REM    = 3'd6;
   localparam logic [2:0] MULDIV_OP_REMU   = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_DIV  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } muldiv_state_e;

   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   // Bring an operand to the working width W (32 or 64), extended to 64 bits
   // so that sign tests and special-case compares are width independent.
   function automatic logic [63:0] fit_op(input logic [63:0] v, input logic w32,
                                          input logic sgn);
      if (w32) return sgn ? sext32(v[31:0]) : {32'b0, v[31:0]};
      return v;
   endfunction

   function automatic logic [63:0] abs_op(input logic [63:0] v, input logic sgn);
      return (sgn && v[63]) ? -v : v;
   endfunction

   // 32-bit results are always returned sign-extended.
   function automatic logic [63:0] word_res(input logic [63:0] v, input logic w32);
      return w32 ? sext32(v[31:0]) : v;
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the muldiv unit.
interface muldiv_if #(
   parameter int XLEN  = 64,
   parameter int TAG_W = 5
);
   logic             flush_i;
   logic             req_valid_i;
   logic             ready_o;
   logic [2:0]       op_i;
   logic             word_i;
   logic [XLEN-1:0]  op_1_i;
   logic [XLEN-1:0]  op_2_i;
   logic [TAG_W-1:0] tag_i;
   logic             resp_ready_i;
   logic             valid_o;
   logic [XLEN-1:0]  result_o;
   logic [TAG_W-1:0] tag_o;

   modport master (
      output flush_i, req_valid_i, op_i, word_i, op_1_i, op_2_i, tag_i, resp_ready_i,
      input  ready_o, valid_o, result_o, tag_o
   );

   modport slave (
      input  flush_i, req_valid_i, op_i, word_i, op_1_i, op_2_i, tag_i, resp_ready_i,
      output ready_o, valid_o, result_o, tag_o
   );
endinterface

// File: rtl/muldiv_div_iter.sv
// One radix-2 restoring divide step: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, shift the quotient bit
// into the vacated low end of the dividend register.
module muldiv_div_iter
   import muldiv_pkg::*;
#(
   parameter int W = 64
) (
   input  logic [W-1:0] rem,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_next,
   output logic [W-1:0] dividend_next
);
   logic [W:0]   shifted;
   logic [W-1:0] diff;
   logic         ge;

   // Trial subtraction; the difference always fits W bits when it is kept.
   always_comb begin
      shifted       = {rem, dividend[W-1]};
      ge            = shifted >= {1'b0, divisor};
      diff          = shifted[W-1:0] - divisor;
      rem_next      = ge ? diff : shifted[W-1:0];
      dividend_next = {dividend[W-2:0], ge};
   end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M/RV64M multiply/divide unit. Operands are converted to
// magnitudes on accept, iterated (MUL_BITS per cycle shift-add, or restoring
// divide), then sign-corrected in FIX. Word ops are placed in the top half of
// the XLEN registers so the MSB-first iteration needs no separate datapath.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN     = 64,
   parameter int MUL_BITS = 2,
   parameter int TAG_W    = 5
) (
   input  logic    clk,
   input  logic    rst,
   muldiv_if.slave bus
);
   localparam int PW = 2 * XLEN;
   localparam int CW = $clog2(XLEN + 1);

   muldiv_state_e            state;
   logic [CW-1:0]            cnt, last;
   logic [2:0]               op_q;
   logic                     w32_q, neg1_q, neg2_q;
   logic [XLEN-1:0]          a_q, b_q, result_q;
   logic [PW-1:0]            prod_q;
   logic [TAG_W-1:0]         tag_q;

   logic                     accept, is_div, is_mulh, w32, s1, s2, neg1, neg2, special;
   logic [63:0]              x1, x2, abs1, abs2, spec_res, fix_res;
   logic [XLEN-1:0]          lo1, lo2, quo, rmd, div_rem, div_dvd;
   logic [MUL_BITS-1:0]      mdig;
   logic [XLEN+MUL_BITS-1:0] pp;
   logic [PW-1:0]            mul_next, pneg;

   assign bus.ready_o  = (state == ST_IDLE);
   assign bus.valid_o  = (state == ST_DONE);
   assign bus.result_o = result_q;
   assign bus.tag_o    = tag_q;
   assign accept       = bus.req_valid_i && (state == ST_IDLE) && !bus.flush_i;

   // Decode the incoming request: width, signedness, magnitudes, special cases.
   always_comb begin
      is_div   = bus.op_i[2];
      is_mulh  = !bus.op_i[2] && (bus.op_i != MULDIV_OP_MUL);
      w32      = (XLEN == 32) || (bus.word_i && !is_mulh);
      s1       = !((bus.op_i == MULDIV_OP_MULHU) || (bus.op_i == MULDIV_OP_DIVU) ||
                   (bus.op_i == MULDIV_OP_REMU));
      s2       = s1 && (bus.op_i != MULDIV_OP_MULHSU);
      x1       = fit_op(64'(bus.op_1_i), w32, s1);
      x2       = fit_op(64'(bus.op_2_i), w32, s2);
      neg1     = s1 && x1[63];
      neg2     = s2 && x2[63];
      abs1     = abs_op(x1, s1);
      abs2     = abs_op(x2, s2);
      lo1      = XLEN'(abs1);
      lo2      = XLEN'(abs2);
      if (w32) begin
         lo1 = lo1 << (XLEN - 32);
         lo2 = lo2 << (XLEN - 32);
      end
      special  = 1'b0;
      spec_res = '0;
      if (is_div && x2 == '0) begin
         special  = 1'b1;
         spec_res = bus.op_i[1] ? x1 : '1;
      end else if (is_div && s1 && x2 == '1 &&
                   x1 == (w32 ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) begin
         special  = 1'b1;
         spec_res = bus.op_i[1] ? '0 : x1;
      end
   end

   // Multiplier step (MSB-first digits of b_q) and iteration limit.
   always_comb begin
      mdig     = b_q[XLEN-1 -: MUL_BITS];
      pp       = {{MUL_BITS{1'b0}}, a_q} * {{XLEN{1'b0}}, mdig};
      mul_next = (prod_q << MUL_BITS) + {{(PW-XLEN-MUL_BITS){1'b0}}, pp};
      if (state == ST_MUL) last = w32_q ? CW'(32/MUL_BITS - 1) : CW'(XLEN/MUL_BITS - 1);
      else                 last = w32_q ? CW'(31) : CW'(XLEN - 1);
   end

   muldiv_div_iter #(.W(XLEN)) u_div_iter (
      .rem           (prod_q[PW-1:XLEN]),
      .dividend      (prod_q[XLEN-1:0]),
      .divisor       (b_q),
      .rem_next      (div_rem),
      .dividend_next (div_dvd)
   );

   // Sign correction and result selection; remainder follows the dividend sign.
   always_comb begin
      pneg    = (neg1_q ^ neg2_q) ? -prod_q : prod_q;
      quo     = prod_q[XLEN-1:0];
      rmd     = prod_q[PW-1:XLEN];
      fix_res = '0;
      case (op_q)
         MULDIV_OP_MUL:                   fix_res = 64'(pneg[XLEN-1:0]);
         MULDIV_OP_MULH, MULDIV_OP_MULHSU,
         MULDIV_OP_MULHU:                 fix_res = 64'(pneg[PW-1:XLEN]);
         MULDIV_OP_DIV, MULDIV_OP_DIVU:   fix_res = (neg1_q ^ neg2_q) ? -(64'(quo)) : 64'(quo);
         default:                         fix_res = neg1_q ? -(64'(rmd)) : 64'(rmd);
      endcase
   end

   // Control FSM plus operand/product registers; flush abandons any work.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         op_q     <= '0;
         w32_q    <= 1'b0;
         neg1_q   <= 1'b0;
         neg2_q   <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         prod_q   <= '0;
         result_q <= '0;
         tag_q    <= '0;
      end else if (bus.flush_i) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: if (accept) begin
               op_q   <= bus.op_i;
               w32_q  <= w32;
               neg1_q <= neg1;
               neg2_q <= neg2;
               tag_q  <= bus.tag_i;
               cnt    <= '0;
               a_q    <= XLEN'(abs1);
               b_q    <= is_div ? XLEN'(abs2) : lo2;
               prod_q <= is_div ? PW'(lo1) : '0;
               if (special) begin
                  result_q <= XLEN'(word_res(spec_res, w32));
                  state    <= ST_DONE;
               end else begin
                  state <= is_div ? ST_DIV : ST_MUL;
               end
            end
            ST_MUL: begin
               prod_q <= mul_next;
               b_q    <= b_q << MUL_BITS;
               cnt    <= cnt + 1'b1;
               if (cnt == last) state <= ST_FIX;
            end
            ST_DIV: begin
               prod_q <= {div_rem, div_dvd};
               cnt    <= cnt + 1'b1;
               if (cnt == last) state <= ST_FIX;
            end
            ST_FIX: begin
               result_q <= XLEN'(word_res(fix_res, w32_q));
               state    <= ST_DONE;
            end
            ST_DONE: if (bus.resp_ready_i) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit for the EX stage, covering the full RISC-V M/RV64M operation set with a single result per request. Multiply retires MUL_BITS bits per cycle; divide is radix-2 restoring. Both share one FSM, one operand register set and a valid/ready handshake on each side. A flush input kills in-flight work on a pipeline redirect; a tag travels with each request so the core can match results.

## Interface
Parameters:
- XLEN, 64, datapath width; 32 or 64.
- MUL_BITS, 2, multiplier bits per iteration; 1, 2, 4 or 8; must divide 32.
- TAG_W, 5, request tag width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- flush_i  in  1  kill current operation.
- req_valid_i  in  1  request present.
- ready_o  out  1  unit can accept a request.
- op_i  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- word_i  in  1  RV64 W-variant; ignored when XLEN=32.
- op_1_i, op_2_i  in  XLEN  rs1, rs2.
- tag_i  in  TAG_W  request tag.
- resp_ready_i  in  1  consumer accepts result.
- valid_o  out  1  result valid.
- result_o  out  XLEN  selected result.
- tag_o  out  TAG_W  tag of the result.

## Operation
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- ready_o is 1 only in IDLE.
- Accept: req_valid_i & ready_o & !flush_i. On accept, latch operands, op, word and tag.
- On accept, take absolute values per signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: op_1 signed.
  - MULHU, DIVU, REMU: unsigned.
- Word ops: use the low 32 bits, sign- or zero-extended per op; final result is the low 32 bits sign-extended to XLEN.
- word_i with MULH/MULHSU/MULHU is treated as word_i=0.
- Iteration count N:
  - Multiply: W/MUL_BITS, where W = 32 for word ops, else XLEN.
  - Divide: W.
- MUL state: shift-add MUL_BITS multiplier bits per cycle into a 2W-bit product register.
- DIV state: one restoring step per cycle, giving quotient and remainder.
- Both use an iteration counter; after N iterations go to FIX.
- FIX: apply sign correction and select the result:
  - Product: negate if operand signs differ. MUL takes the low W bits; MULH* take the high W bits.
  - Quotient: negate if signs differ.
  - Remainder: takes the dividend's sign.
- Special cases bypass iteration: IDLE goes straight to DONE with the result ready.
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return the dividend.
  - Signed overflow (most-negative / -1, at width W): DIV returns the dividend; REM returns 0.
- DONE: valid_o=1; result_o and tag_o are held stable until resp_ready_i=1, then go to IDLE.
- flush_i: from any state, go to IDLE next cycle; valid_o=0 next cycle. A request in the same cycle is not accepted. A pending DONE result is discarded.

## Timing
- Reset values: ready_o=1, valid_o=0, result_o=0, tag_o=0, state IDLE, counter 0.
- Accept edge is cycle 0.
  - Normal op: iterations run cycles 1..N, FIX is cycle N+1, valid_o rises in cycle N+2.
  - XLEN=64, MUL_BITS=2: MUL 64-bit valid at cycle 34; MULW at cycle 18.
  - DIV 64-bit valid at cycle 66; DIVW at cycle 34.
  - Special case: valid_o in cycle 1.
- Response handshake in cycle k: ready_o=1 in cycle k+1. Minimum gap between accepts is N+3 cycles.
- Reset mid-operation: state and outputs return to their reset values on the next edge; no result is emitted.
- Backpressure: DONE is held indefinitely; no new request is accepted while in DONE.

## Structure
- Package muldiv_pkg holds:
  - op encoding constants (MULDIV_OP_*);
  - the state enum (muldiv_state_e);
  - helper functions for sign/abs and word sign-extension.
- Sub-module muldiv_div_iter: one restoring step (partial remainder, dividend shift) as a combinational stage with width parameter W. Instantiated once.
- Multiplier step, FSM, operand registers and result select live in muldiv_unit.

## Test plan
- MUL 0x7 × 0xFFFF_FFFF_FFFF_FFFD (−3), XLEN=64, MUL_BITS=2 → result 0xFFFF_FFFF_FFFF_FFEB, valid_o at cycle 34, tag echoed.
- MULHU 0xFFFF_FFFF_FFFF_FFFF × 0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE.
- MULHSU (−1) × 2 → 0xFFFF_FFFF_FFFF_FFFF.
- DIV −7 / 2 → 0xFFFF_FFFF_FFFF_FFFD (−3); REM −7 / 2 → 0xFFFF_FFFF_FFFF_FFFF (−1); valid_o at cycle 66.
- DIVW: op_1=0x0000_0001_8000_0000, op_2=0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000 (overflow case), valid_o at cycle 1.
- REMU x / 0 (x=0x1234) → 0x1234, valid_o at cycle 1.
- Flush asserted at cycle 10 of a DIV → IDLE at cycle 11, ready_o=1, no valid_o.
- Hold resp_ready_i=0 for 20 cycles after valid_o → result_o and tag_o stable, ready_o=0.
- Assert rst=0 mid-MUL → reset values on the next edge.
